// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types for the instruction fetch unit.
//   XLEN          : word / word-address width
//   word_t        : one instruction word or one word address
//   fetch_state_e : fetch FSM states (RUN, DRAIN, HALTED)
//   fifo_entry_t  : one instruction buffer entry {pc, instr}
//   next_pc()     : sequential word address, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    // Addressing is by word, so the next sequential address is +1; the
    // 32-bit add wraps 32'hFFFF_FFFF to 0 on its own.
    function automatic word_t next_pc(input word_t pc);
        return pc + word_t'(1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Bundles the fetch unit's memory, redirect/halt and instruction-delivery
// signals.
//   master : the fetch unit (drives mem_addr, instr*, halted, state)
//   slave  : the environment (memory, branch unit, consumer)
//
// Delivery handshake: instr_valid says instr/instr_pc hold a buffered
// instruction; the word is transferred at the rising edge that ends a cycle
// in which instr_valid && instr_ready. While instr_valid && !instr_ready the
// producer keeps instr, instr_pc and instr_valid stable. instr_valid never
// depends combinationally on instr_ready.
// -----------------------------------------------------------------------------
interface fetch_if;
    import fetch_pkg::*;

    // instruction memory
    word_t        mem_addr;
    word_t        mem_rdata;
    // control
    logic         redirect_valid;
    word_t        redirect_pc;
    logic         halt_req;
    logic         halted;
    // instruction delivery
    logic         instr_valid;
    word_t        instr;
    word_t        instr_pc;
    logic         instr_ready;
    // FSM state, for observation only
    fetch_state_e state;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req,
        output halted,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready,
        output state
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        output halt_req,
        input  halted,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready,
        input  state
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous instruction buffer with flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the rising edge
//   push_data  : entry to write
//   pop        : drop the head entry at the rising edge (ignored when empty)
//   flush      : empty the buffer; wins over push and pop
//   head_data  : head entry, all zeros when empty
//   count      : number of stored entries (0..DEPTH)
//   empty      : count == 0
// DEPTH must be a power of two and at least 2 so the pointers wrap freely.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; the write then lands in the slot being vacated.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only read through head_data, which is
    // forced to zero while the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

    // The fetch side reserves a slot before issuing, so this never fires in
    // a correct system.
    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetcher with a small instruction buffer, halt and
// redirect support.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus.mem_addr        : registered word address to instruction memory
//   bus.mem_rdata       : word at mem_addr, valid the cycle after it is issued
//   bus.redirect_valid  : one-cycle pulse, restart fetch at bus.redirect_pc
//   bus.halt_req        : level, stop issuing new fetches
//   bus.halted          : high in HALTED
//   bus.instr_valid/instr/instr_pc/instr_ready : buffered instruction output
//   bus.state           : current FSM state
// Parameters:
//   RESET_PC   : first word address fetched after reset
//   FIFO_DEPTH : instruction buffer entries (power of two, >= 2)
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC   = 32'h0000_0000,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e   state;
    word_t          fetch_pc;
    word_t          mem_addr_q;
    logic           pending;
    logic           halted_q;

    logic [CW-1:0]  count;
    logic           fifo_empty;
    logic [CW:0]    occupancy;
    logic           issue;
    logic           push;
    logic           pop;
    logic           flush;
    fifo_entry_t    push_entry;
    fifo_entry_t    head;

    // A slot is reserved for the word still in flight, so issuing only when
    // buffered + in-flight < depth guarantees the push always has room.
    // The pop of this cycle is deliberately not credited.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
    assign issue     = (state == RUN) && !bus.halt_req && !bus.redirect_valid
                       && (occupancy < (CW+1)'(FIFO_DEPTH));

    // mem_addr only moves on an issue, so while pending is set it still
    // holds the address of the word now on mem_rdata.
    assign push_entry = '{pc: mem_addr_q, instr: bus.mem_rdata};
    assign flush      = bus.redirect_valid;
    assign push       = pending && !bus.redirect_valid;
    assign pop        = !fifo_empty && bus.instr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            mem_addr_q <= RESET_PC;
            pending    <= 1'b0;
            halted_q   <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect beats halt_req; the in-flight word is dropped by
            // clearing pending, the buffer by the flush.
            state    <= RUN;
            fetch_pc <= bus.redirect_pc;
            pending  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pending <= issue;
            if (issue) begin
                mem_addr_q <= fetch_pc;
                fetch_pc   <= next_pc(fetch_pc);
            end
            case (state)
                RUN: begin
                    if (bus.halt_req) begin
                        // With a word in flight it is pushed at this edge;
                        // DRAIN then spends one quiet cycle before HALTED.
                        if (pending) begin
                            state <= DRAIN;
                        end else begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state    <= HALTED;
                    halted_q <= 1'b1;
                end
                HALTED: begin
                    // Only a redirect leaves HALTED.
                    halted_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head),
        .count     (count),
        .empty     (fifo_empty)
    );

    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.halted      = halted_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: memory model, driver tasks, scoreboard
// of expected {pc, instr} words, directed sequences and a redirect table.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          SB_SPAN  = 64;

    typedef struct {
        logic [31:0] pc;
        int          cycles;
        int          exp_n;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks      = 0;
    int failures    = 0;
    int n_delivered = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_word;
    logic [31:0] head_pc;
    vec_t        vecs[6];

    fetch_if bus ();

    fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    assign bus.mem_rdata = instr_of(bus.mem_addr);

    // ---------------- driver / helper tasks ----------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Restart the expected stream at pc: pc, pc+1, ... (32-bit wrap).
    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        exp_q.delete();
        for (int i = 0; i < SB_SPAN; i++) begin
            exp_q.push_back({p, instr_of(p)});
            p = p + 32'd1;
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        bus.redirect_pc    = pc;
        bus.redirect_valid = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        sb_restart(pc);
        check("redirect_flush_valid", 64'(bus.instr_valid), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            n_delivered++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got pc %h, expected no delivery",
                         bus.instr_pc);
            end else begin
                exp_word = exp_q.pop_front();
                check("sb_word", {bus.instr_pc, bus.instr}, exp_word);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{pc: 32'h0000_1000, cycles: 6, exp_n: 4};
        vecs[1] = '{pc: 32'hFFFF_FFFE, cycles: 5, exp_n: 3};
        vecs[2] = '{pc: 32'h7FFF_FFFF, cycles: 8, exp_n: 6};
        vecs[3] = '{pc: 32'h0000_0040, cycles: 3, exp_n: 1};
        vecs[4] = '{pc: 32'h0000_0002, cycles: 2, exp_n: 0};
        vecs[5] = '{pc: 32'hABCD_0000, cycles: 4, exp_n: 2};

        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt_req       = 1'b0;
        bus.instr_ready    = 1'b1;

        // Reset values.
        steps(2);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(RESET_PC));
        check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_instr", 64'(bus.instr), 64'd0);
        check("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
        check("rst_halted", 64'(bus.halted), 64'd0);
        check("rst_state", 64'(bus.state), 64'(RUN));

        // First fetch latency and back-to-back delivery.
        sb_restart(RESET_PC);
        rst_n = 1'b1;
        step();
        check("lat_not_yet_valid", 64'(bus.instr_valid), 64'd0);
        step();
        check("lat_valid", 64'(bus.instr_valid), 64'd1);
        check("lat_pc0", 64'(bus.instr_pc), 64'(RESET_PC));
        check("lat_instr0", 64'(bus.instr), 64'(instr_of(RESET_PC)));
        check("lat_mem_addr1", 64'(bus.mem_addr), 64'(RESET_PC + 32'd1));
        step();
        check("seq_pc1", 64'(bus.instr_pc), 64'(RESET_PC + 32'd1));
        step();
        check("seq_pc2", 64'(bus.instr_pc), 64'(RESET_PC + 32'd2));

        // Consumer stall: buffer fills to DEPTH and fetch stops.
        bus.instr_ready = 1'b0;
        steps(6);
        head_pc = exp_q[0][63:32];
        check("stall_head_pc", 64'(bus.instr_pc), 64'(head_pc));
        check("stall_mem_addr", 64'(bus.mem_addr), 64'(head_pc + 32'(DEPTH - 1)));
        steps(4);
        check("stall_head_hold", 64'(bus.instr_pc), 64'(head_pc));
        check("stall_mem_addr_hold", 64'(bus.mem_addr), 64'(head_pc + 32'(DEPTH - 1)));
        check("stall_valid", 64'(bus.instr_valid), 64'd1);
        n_delivered     = 0;
        bus.instr_ready = 1'b1;
        steps(8);
        check("stall_release_count", 64'(n_delivered), 64'd8);

        // Redirect with three buffered words and one in flight.
        bus.instr_ready = 1'b0;
        do_redirect(32'h0000_0100);
        steps(4);
        check("pre_redir_valid", 64'(bus.instr_valid), 64'd1);
        check("pre_redir_head", 64'(bus.instr_pc), 64'h100);
        check("pre_redir_mem_addr", 64'(bus.mem_addr), 64'h103);
        do_redirect(32'h0000_0040);
        bus.instr_ready = 1'b1;
        n_delivered     = 0;
        steps(6);
        check("redir_count", 64'(n_delivered), 64'd4);

        // Redirect table, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            do_redirect(vecs[v].pc);
            n_delivered = 0;
            steps(vecs[v].cycles);
            check($sformatf("vec%0d_count", v), 64'(n_delivered),
                  64'(vecs[v].exp_n));
        end

        // Halt with a word in flight, then resume by redirect.
        bus.instr_ready = 1'b0;
        do_redirect(32'h0000_0200);
        steps(3);
        bus.halt_req = 1'b1;
        step();
        check("halt_drain_state", 64'(bus.state), 64'(DRAIN));
        check("halt_drain_halted", 64'(bus.halted), 64'd0);
        step();
        check("halt_state", 64'(bus.state), 64'(HALTED));
        check("halt_halted", 64'(bus.halted), 64'd1);
        check("halt_mem_addr", 64'(bus.mem_addr), 64'h202);
        bus.halt_req    = 1'b0;
        bus.instr_ready = 1'b1;
        n_delivered     = 0;
        steps(6);
        check("halt_drain_count", 64'(n_delivered), 64'd3);
        check("halt_mem_frozen", 64'(bus.mem_addr), 64'h202);
        check("halt_stays", 64'(bus.halted), 64'd1);
        check("halt_empty", 64'(bus.instr_valid), 64'd0);
        do_redirect(32'h0000_0010);
        check("resume_halted", 64'(bus.halted), 64'd0);
        check("resume_state", 64'(bus.state), 64'(RUN));
        n_delivered = 0;
        steps(5);
        check("resume_count", 64'(n_delivered), 64'd3);

        // Asynchronous reset mid-stream.
        bus.instr_ready = 1'b0;
        do_redirect(32'h0000_0300);
        steps(4);
        check("prereset_valid", 64'(bus.instr_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        check("async_rst_valid", 64'(bus.instr_valid), 64'd0);
        check("async_rst_mem_addr", 64'(bus.mem_addr), 64'(RESET_PC));
        check("async_rst_instr_pc", 64'(bus.instr_pc), 64'd0);
        steps(2);
        sb_restart(RESET_PC);
        bus.instr_ready = 1'b1;
        rst_n           = 1'b1;
        n_delivered     = 0;
        steps(6);
        check("post_rst_count", 64'(n_delivered), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
